// File: rtl/preambula_stream_framer_if.sv
// Bus bundle between the preamble framer, its ROM address counter / ROM
// pair and the downstream OFDM symbol mux.
//   master : the framer (drives ROM enable/ready and the output stream)
//   slave  : the environment (drives ROM flags/data and out_ready)
interface preambula_stream_framer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7
) ();

  // ROM counter side
  logic                  rom_en;
  logic                  rom_ready;
  logic                  rom_valid;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0] rom_data;

  // Framed output stream
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_sof;
  logic                  out_eof;

  modport master (
    output rom_en, rom_ready, out_data, out_valid, out_sof, out_eof,
    input  rom_valid, rom_addr, rom_data, out_ready
  );

  modport slave (
    input  rom_en, rom_ready, out_data, out_valid, out_sof, out_eof,
    output rom_valid, rom_addr, rom_data, out_ready
  );

endinterface

// File: rtl/preambula_stream_framer.sv
// Preamble stream framer.
// Pulls PRE_LEN samples from the preamble ROM (through its address counter),
// realigns the ROM output to the ROM read latency with a shift register of
// issue flags, buffers samples in a 4-entry first-word-fall-through FIFO and
// emits one framed preamble (sof/eof markers, valid/ready) per start request.
// Optional feature macro: PREAMBULA_ALIGN_CHECK_EN -- when defined, every
// issued ROM address is compared against the framer's own issue count and a
// mismatch sets the sticky align_err flag. When undefined align_err is 0.
module preambula_stream_framer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7,
  parameter int PRE_LEN    = 107,
  parameter int ROM_LAT    = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  preambula_stream_framer_if.master bus,
  output logic busy,
  output logic done,
  output logic align_err
);

  localparam int ICNT_W     = $clog2(PRE_LEN + 1);
  localparam int IDX_W      = $clog2(PRE_LEN);
  localparam int FIFO_DEPTH = 4;

  localparam logic [ICNT_W-1:0] PRE_LEN_C  = ICNT_W'(PRE_LEN);
  localparam logic [IDX_W-1:0]  IDX_LAST_C = IDX_W'(PRE_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ICNT_W-1:0]   issue_cnt_q, issue_cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [ROM_LAT-1:0]  issue_vld_q, issue_vld_d;
  logic [1:0]          wr_ptr_q, wr_ptr_d;
  logic [1:0]          rd_ptr_q, rd_ptr_d;
  logic [2:0]          count_q, count_d;
  logic                busy_q, busy_d;
  logic                rom_en_q, rom_en_d;
  logic                done_q, done_d;
  logic                align_err_q, align_err_d;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic [1:0] pending;
  logic [3:0] level;
  logic       rom_ready_c;
  logic       issue;
  logic       push;
  logic       pop;
  logic       out_valid_c;
  logic       addr_mismatch;

  // Count ROM reads still in flight (issued but not yet landed in the FIFO).
  always_comb begin
    pending = '0;
    for (int i = 0; i < ROM_LAT; i++) begin
      pending = pending + {1'b0, issue_vld_q[i]};
    end
  end

  // Reads are only issued while the FIFO can absorb everything in flight, so a
  // landing sample always finds a free slot. Depends on registered state only.
  always_comb begin
    level       = {1'b0, count_q} + {2'b00, pending};
    rom_ready_c = rom_en_q && (level < 4'(FIFO_DEPTH)) && (issue_cnt_q < PRE_LEN_C);
    issue       = rom_en_q && rom_ready_c && bus.rom_valid;
    push        = issue_vld_q[ROM_LAT-1];
    out_valid_c = (count_q != 3'd0);
    pop         = out_valid_c && bus.out_ready;
  end

`ifdef PREAMBULA_ALIGN_CHECK_EN
  // Counter address must track our own issue count on every issued read.
  always_comb begin
    addr_mismatch = issue &&
      ({{(32-ADDR_WIDTH){1'b0}}, bus.rom_addr} != {{(32-ICNT_W){1'b0}}, issue_cnt_q});
  end
`else
  logic [ADDR_WIDTH-1:0] unused_rom_addr;
  assign unused_rom_addr = bus.rom_addr;
  assign addr_mismatch   = 1'b0;
`endif

  // Next-state logic: frame FSM, issue/output counters, latency line, FIFO pointers.
  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    idx_d       = idx_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    done_d      = 1'b0;
    align_err_d = align_err_q | addr_mismatch;

    // Issue flags travel ROM_LAT cycles so the tail lines up with rom_data.
    issue_vld_d    = '0;
    issue_vld_d[0] = issue;
    for (int i = 1; i < ROM_LAT; i++) begin
      issue_vld_d[i] = issue_vld_q[i-1];
    end

    if (issue) begin
      issue_cnt_d = issue_cnt_q + 1'b1;
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + 2'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
      idx_d    = (idx_q == IDX_LAST_C) ? '0 : idx_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = RUN;
          issue_cnt_d = '0;
          idx_d       = '0;
        end
      end
      RUN: begin
        if (issue_cnt_q == PRE_LEN_C) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && (idx_q == IDX_LAST_C)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d   = (state_d != IDLE);
    rom_en_d = (state_d == RUN);
  end

  // Control state and registered outputs; reset discards in-flight reads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      issue_cnt_q <= '0;
      idx_q       <= '0;
      issue_vld_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      busy_q      <= 1'b0;
      rom_en_q    <= 1'b0;
      done_q      <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      idx_q       <= idx_d;
      issue_vld_q <= issue_vld_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      busy_q      <= busy_d;
      rom_en_q    <= rom_en_d;
      done_q      <= done_d;
      align_err_q <= align_err_d;
    end
  end

  // FIFO storage; contents are don't-care while the matching count is zero.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.rom_data;
    end
  end

  // Head of FIFO is masked to zero when empty so reset clears out_data at once.
  assign bus.out_data  = out_valid_c ? mem_q[rd_ptr_q] : '0;
  assign bus.out_valid = out_valid_c;
  assign bus.out_sof   = out_valid_c && (idx_q == '0);
  assign bus.out_eof   = out_valid_c && (idx_q == IDX_LAST_C);
  assign bus.rom_en    = rom_en_q;
  assign bus.rom_ready = rom_ready_c;
  assign busy          = busy_q;
  assign done          = done_q;
  assign align_err     = align_err_q;

endmodule

// File: tb/tb_preambula_stream_framer.sv
// Bench for preambula_stream_framer: one instance at ROM_LAT=1 (cycle table,
// sustained, stall, start-ignore, reset and address-offset scenarios) and one
// at ROM_LAT=3 with random out_ready. Each instance is fed by a model of the
// wrapping address counter and a synchronous ROM whose data equals its address.
module tb_preambula_stream_framer;

  localparam int PRE_LEN = 107;

`ifdef PREAMBULA_ALIGN_CHECK_EN
  localparam logic ALIGN_EXP = 1'b1;
`else
  localparam logic ALIGN_EXP = 1'b0;
`endif

  logic clk;
  logic reset_n;
  logic start1, start3;
  logic busy1, done1, aerr1;
  logic busy3, done3, aerr3;
  logic [6:0] addr_off;

  int n_checks;
  int n_errors;

  preambula_stream_framer_if #(.DATA_WIDTH(32), .ADDR_WIDTH(7)) b1 ();
  preambula_stream_framer_if #(.DATA_WIDTH(32), .ADDR_WIDTH(7)) b3 ();

  preambula_stream_framer #(
    .DATA_WIDTH(32), .ADDR_WIDTH(7), .PRE_LEN(PRE_LEN), .ROM_LAT(1)
  ) u_dut1 (
    .clk(clk), .reset(reset_n), .start(start1), .bus(b1.master),
    .busy(busy1), .done(done1), .align_err(aerr1)
  );

  preambula_stream_framer #(
    .DATA_WIDTH(32), .ADDR_WIDTH(7), .PRE_LEN(PRE_LEN), .ROM_LAT(3)
  ) u_dut3 (
    .clk(clk), .reset(reset_n), .start(start3), .bus(b3.master),
    .busy(busy3), .done(done3), .align_err(aerr3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Address counter + ROM model, latency 1
  logic [6:0]  cnt1;
  logic [31:0] rd1;
  assign b1.rom_valid = b1.rom_en & b1.rom_ready;
  assign b1.rom_addr  = cnt1 + addr_off;
  assign b1.rom_data  = rd1;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt1 <= '0;
      rd1  <= '0;
    end else begin
      if (b1.rom_valid) cnt1 <= (cnt1 == 7'(PRE_LEN-1)) ? 7'd0 : cnt1 + 7'd1;
      rd1 <= {25'd0, b1.rom_addr};
    end
  end

  // Address counter + ROM model, latency 3, plus issue/pop tallies
  logic [6:0]  cnt3;
  logic [31:0] rd3 [3];
  int          iss3, pop3;
  assign b3.rom_valid = b3.rom_en & b3.rom_ready;
  assign b3.rom_addr  = cnt3;
  assign b3.rom_data  = rd3[2];
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt3   <= '0;
      rd3[0] <= '0;
      rd3[1] <= '0;
      rd3[2] <= '0;
      iss3   <= 0;
      pop3   <= 0;
    end else begin
      if (b3.rom_valid) cnt3 <= (cnt3 == 7'(PRE_LEN-1)) ? 7'd0 : cnt3 + 7'd1;
      rd3[0] <= {25'd0, b3.rom_addr};
      rd3[1] <= rd3[0];
      rd3[2] <= rd3[1];
      if (b3.rom_valid) iss3 <= iss3 + 1;
      if (b3.out_valid && b3.out_ready) pop3 <= pop3 + 1;
    end
  end

  typedef struct {
    logic        start;
    logic        rdy;
    logic        busy;
    logic        rom_en;
    logic        rom_ready;
    logic        valid;
    logic [31:0] data;
    logic        sof;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},   busy1, 0);
    chk({tag, "_rom_en"}, b1.rom_en, 0);
    chk({tag, "_rom_rdy"}, b1.rom_ready, 0);
    chk({tag, "_valid"},  b1.out_valid, 0);
    chk({tag, "_sof"},    b1.out_sof, 0);
    chk({tag, "_eof"},    b1.out_eof, 0);
    chk({tag, "_done"},   done1, 0);
    chk({tag, "_aerr"},   aerr1, 0);
    chk({tag, "_data"},   b1.out_data, 0);
  endtask

  // Consume the rest of a frame on instance 1.
  // mode 0: out_ready high; mode 1: 10-cycle stall; mode 2: high + start pulses in RUN/DRAIN
  task automatic drain1(input int first, input int mode);
    int          idx = first;
    int          cyc = 0;
    int          first_pop = -1;
    int          last_pop = -1;
    bit          seen_done = 0;
    bit          stalled = 0;
    bit          drain_pulsed = 0;
    logic [31:0] hold = '0;
    while (!seen_done && cyc < 3000) begin
      tick();
      cyc++;
      start1 = 1'b0;
      b1.out_ready = !(mode == 1 && cyc >= 40 && cyc <= 49);
      if (mode == 2) begin
        if (cyc == 20) start1 = 1'b1;
        if (busy1 && !b1.rom_en && !drain_pulsed) begin
          start1 = 1'b1;
          drain_pulsed = 1;
        end
      end
      if (stalled) chk("stall_hold_data", b1.out_data, hold);
      if (mode == 1 && cyc == 49) begin
        chk("stall_rom_ready", b1.rom_ready, 0);
        chk("stall_valid", b1.out_valid, 1);
      end
      stalled = b1.out_valid && !b1.out_ready;
      hold = b1.out_data;
      if (done1) begin
        seen_done = 1;
        chk("done_after_eof", cyc, last_pop + 1);
        chk("busy_at_done", busy1, 0);
        chk("sample_count", idx, PRE_LEN);
      end else if (b1.out_valid && b1.out_ready) begin
        chk("data", b1.out_data, idx);
        chk("sof", b1.out_sof, idx == 0);
        chk("eof", b1.out_eof, idx == PRE_LEN - 1);
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
        idx++;
      end
    end
    chk("done_seen", seen_done, 1);
    if (mode == 2) begin
      chk("first_valid_lat1", first_pop, 3);
      chk("throughput", last_pop - first_pop, PRE_LEN - 1);
      chk("drain_start_pulsed", drain_pulsed, 1);
    end
    tick();
    chk("done_one_cycle", done1, 0);
    chk("idle_after_done", busy1, 0);
    tick();
    chk("no_second_frame", busy1, 0);
    chk("empty_after_frame", b1.out_valid, 0);
  endtask

  // Full frame on the ROM_LAT=3 instance with random out_ready.
  task automatic drain3();
    int idx = 0;
    int cyc = 0;
    int first_valid = -1;
    int last_pop = -1;
    bit seen_done = 0;
    while (!seen_done && cyc < 3000) begin
      tick();
      cyc++;
      start3 = 1'b0;
      b3.out_ready = 1'($urandom_range(0, 1));
      chk("lat3_outstanding_le4", (iss3 - pop3) <= 4, 1);
      if (first_valid < 0 && b3.out_valid) first_valid = cyc;
      if (done3) begin
        seen_done = 1;
        chk("lat3_done_after_eof", cyc, last_pop + 1);
        chk("lat3_sample_count", idx, PRE_LEN);
      end else if (b3.out_valid && b3.out_ready) begin
        chk("lat3_data", b3.out_data, idx);
        chk("lat3_sof", b3.out_sof, idx == 0);
        chk("lat3_eof", b3.out_eof, idx == PRE_LEN - 1);
        last_pop = cyc;
        idx++;
      end
    end
    chk("lat3_done_seen", seen_done, 1);
    chk("lat3_first_valid", first_valid, 5);
    tick();
    chk("lat3_idle", busy3, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    n_checks = 0;
    n_errors = 0;
    // start, rdy | busy rom_en rom_ready valid data sof
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'd0, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'd1, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'd1, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'd1, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'd1, 1'b0};
    tbl[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'd2, 1'b0};
    tbl[9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'd3, 1'b0};

    reset_n = 1'b0;
    start1 = 1'b0;
    start3 = 1'b0;
    addr_off = '0;
    b1.out_ready = 1'b0;
    b3.out_ready = 1'b0;
    #12;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Frame 1: cycle table from the start request, then the rest of the frame
    for (int i = 0; i < 10; i++) begin
      tick();
      start1 = tbl[i].start;
      b1.out_ready = tbl[i].rdy;
      chk($sformatf("tbl%0d_busy", i),    busy1,         tbl[i].busy);
      chk($sformatf("tbl%0d_rom_en", i),  b1.rom_en,     tbl[i].rom_en);
      chk($sformatf("tbl%0d_rom_rdy", i), b1.rom_ready,  tbl[i].rom_ready);
      chk($sformatf("tbl%0d_valid", i),   b1.out_valid,  tbl[i].valid);
      chk($sformatf("tbl%0d_data", i),    b1.out_data,   tbl[i].data);
      chk($sformatf("tbl%0d_sof", i),     b1.out_sof,    tbl[i].sof);
    end
    drain1(4, 0);

    // Frame 2: sustained rate, start pulses in RUN and DRAIN ignored
    start1 = 1'b1;
    drain1(0, 2);

    // Frame 3: ten-cycle downstream stall mid-frame
    start1 = 1'b1;
    drain1(0, 1);

    // ROM_LAT=3 instance, random back-pressure
    start3 = 1'b1;
    drain3();

    // Reset at sample 50, then a fresh full frame
    start1 = 1'b1;
    found = 0;
    for (int c = 0; c < 400 && !found; c++) begin
      tick();
      start1 = 1'b0;
      b1.out_ready = 1'b1;
      if (b1.out_valid && b1.out_data == 32'd50) found = 1;
    end
    chk("reach_sample_50", found, 1);
    reset_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    chk("post_reset_idle_busy", busy1, 0);
    chk("post_reset_idle_valid", b1.out_valid, 0);
    start1 = 1'b1;
    drain1(0, 0);

    // Counter address offset by one against the issue count
    addr_off = 7'd1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("align_before_issue", aerr1, 0);
    tick();
    chk("align_first_issue", aerr1, ALIGN_EXP);
    repeat (20) tick();
    chk("align_sticky", aerr1, ALIGN_EXP);
    reset_n = 1'b0;
    #1;
    chk("align_cleared_by_reset", aerr1, 0);
    tick();
    reset_n = 1'b1;
    addr_off = '0;
    tick();
    chk("align_stays_clear", aerr1, 0);
    chk("lat3_align_clear", aerr3, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
